// File: rtl/full_adder.sv
// full_adder: single-bit full adder from two half adders, with a registered copy of sum and carry
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);
  assign s  = x ^ y;
  assign co = x & y;
endmodule

module full_adder (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry,
  output logic sum_q,
  output logic carry_q
);
  logic s1, c1, c2;
  half_adder u_ha1 (.x(a),  .y(b), .s(s1),  .co(c1));
  half_adder u_ha2 (.x(s1), .y(c), .s(sum), .co(c2));
  assign carry = c1 | c2;
  always_ff @(posedge clk) begin
    sum_q   <= rst ? 1'b0 : sum;
    carry_q <= rst ? 1'b0 : carry;
  end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: truth-table sweep, registered-path sequences and random stimulus against an arithmetic model
module tb_full_adder;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst, a, b, c;
  logic sum, carry, sum_q, carry_q;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] in;
    logic [1:0] exp;
  } vec_t;

  full_adder dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [1:0] model(input logic [2:0] v);
    return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got {carry,sum}=%b want=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  initial begin
    vec_t tbl[8];
    logic [1:0] exp_q;
    logic [2:0] v;
    tbl[0] = '{3'b000, 2'b00}; tbl[1] = '{3'b001, 2'b01};
    tbl[2] = '{3'b010, 2'b01}; tbl[3] = '{3'b011, 2'b10};
    tbl[4] = '{3'b100, 2'b01}; tbl[5] = '{3'b101, 2'b10};
    tbl[6] = '{3'b110, 2'b10}; tbl[7] = '{3'b111, 2'b11};
    rst = 1'b1;
    drive(3'b000);
    #100;
    chk("init_comb", {carry, sum}, 2'b00);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].in);
      #5;
      chk($sformatf("table_%0d", i), {carry, sum}, tbl[i].exp);
    end
    clk_en = 1'b1;
    // synchronous reset: registers clear while the combinational path keeps adding
    rst = 1'b1;
    drive(3'b111);
    @(negedge clk);
    @(negedge clk);
    chk("rst_q", {carry_q, sum_q}, 2'b00);
    chk("rst_comb", {carry, sum}, 2'b11);
    rst = 1'b0;
    @(negedge clk);
    chk("reg_111", {carry_q, sum_q}, 2'b11);
    drive(3'b010);
    @(negedge clk);
    chk("reg_010", {carry_q, sum_q}, 2'b01);
    rst = 1'b1;
    drive(3'b011);
    @(negedge clk);
    @(negedge clk);
    chk("rel_held", {carry_q, sum_q}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_first", {carry_q, sum_q}, 2'b10);
    drive(3'b001);
    @(negedge clk);
    chk("mid_pre_q", {carry_q, sum_q}, 2'b01);
    chk("mid_pre_comb", {carry, sum}, 2'b01);
    #2;
    drive(3'b110);
    #1;
    chk("mid_comb", {carry, sum}, 2'b10);
    chk("mid_hold_q", {carry_q, sum_q}, 2'b01);
    @(negedge clk);
    chk("mid_post_q", {carry_q, sum_q}, 2'b10);
    for (int i = 0; i < 200; i++) begin
      v = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 7) == 0);
      drive(v);
      #1;
      chk("rand_comb", {carry, sum}, model(v));
      exp_q = rst ? 2'b00 : model(v);
      @(negedge clk);
      chk("rand_q", {carry_q, sum_q}, exp_q);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
